regfile_bypass_sb: RTL

Parametrised general-purpose register file for the MIPS pipeline CPU. It supersedes the fixed 2-read/1-write 32x32 array. Additions over that array:
- configurable width, depth and read-port count
- honoured write enable
- hardwired zero register
- same-cycle write-to-read bypass
- per-register busy scoreboard so decode can detect RAW hazards against in-flight producers

It sits between the ID stage (reads, issue) and the WB stage (writeback).

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/regfile_bypass_sb.sv | 94 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the parametrised register file.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

  // Number of architectural registers addressed by an addr_w-bit index.
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard.
// Decode marks a destination as pending, and writeback clears it.
// A new producer always supersedes the one currently in flight.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_reg,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_reg,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busyNext;

  // Next busy state: an issue sets the bit, otherwise a writeback clears it.
  // Register 0 never becomes busy when it is hardwired to zero.
  always_comb begin
    w_busyNext = r_busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (issue_valid && (issue_reg == ADDR_W'(r))) begin
        w_busyNext[r] = 1'b1;
      end else if (wb_valid && (wb_reg == ADDR_W'(r))) begin
        w_busyNext[r] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      w_busyNext[0] = 1'b0;
    end
  end

  // Busy flops; reset leaves every register free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_bypass_sb.sv
// Parametrised register file with a single write port and NUM_RD read ports.
// It forwards the same-cycle writeback to the read ports and exposes
// per-port busy flags so that decode can detect RAW hazards.
module regfile_bypass_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic [NUM_RD-1:0]        read_busy,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_reg,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_busyVec;
  logic              w_wrDrop;
  logic              w_wbEn;

  // When register 0 is hardwired to zero, writes to it are discarded.
  assign w_wrDrop = (ZERO_REG != 0) && (write_reg == '0);

  // A writeback is only visible to the bypass path outside reset.
  assign w_wbEn = reg_write & rst_n;

  // Register array: reset clears every entry, and a write commits only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        r_regs[r] <= '0;
      end
    end else if (reg_write && !w_wrDrop) begin
      r_regs[write_reg] <= write_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .wb_valid    (reg_write),
    .wb_reg      (write_reg),
    .busy_vec    (w_busyVec)
  );

  assign busy_vec = w_busyVec;

  for (genvar g = 0; g < NUM_RD; g++) begin : gen_rd
    logic [ADDR_W-1:0] w_rdAddr;
    logic              w_bypHit;
    logic              w_issueHit;
    logic [DATA_W-1:0] w_rdData;

    assign w_rdAddr   = read_reg[g*ADDR_W +: ADDR_W];
    assign w_bypHit   = (BYPASS != 0) && w_wbEn && (write_reg == w_rdAddr);
    assign w_issueHit = issue_valid && (issue_reg == w_rdAddr);

    // Read mux: the array value, overridden by the writeback in flight.
    // The result is forced to zero for the zero register or while in reset.
    always_comb begin
      w_rdData = r_regs[w_rdAddr];
      if (w_bypHit) begin
        w_rdData = write_data;
      end
      if (((ZERO_REG != 0) && (w_rdAddr == '0)) || !rst_n) begin
        w_rdData = '0;
      end
    end

    assign read_data[g*DATA_W +: DATA_W] = w_rdData;

    // A producer finishing this cycle is no longer a hazard,
    // unless a new producer is issued to the same register in the same cycle.
    assign read_busy[g] = w_busyVec[w_rdAddr] & ~(w_bypHit & ~w_issueHit);
  end

endmodule
